vg2_activity_monitor: RTL and testbench



---
 rtl/vg2_act_pkg.sv | 30 +++
 rtl/vg2_popcount.sv | 30 +++
 rtl/vg2_activity_monitor.sv | 194 +++++++++++++++++++
 tb/tb_vg2_activity_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vg2_act_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vg2_act_pkg (package)
// Purpose  : Shared types and constants for the vg2 activity monitor.
//            - state_t        : monitor FSM states (IDLE, RUN, HOLD)
//            - *_DEF          : default WIDTH / CNT_W / WIN_W values
//            - tot_width()    : width of the saturating total-toggle counter
// Config   : none (VG2_ACT_PERBIT_EN is consumed by vg2_activity_monitor)
// Revision : 1.0 - initial release
// ============================================================================
package vg2_act_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;

  // The total can reach WIDTH times a per-bit count, so it needs
  // log2(WIDTH) extra bits over a single per-bit counter.
  function automatic int tot_width(input int width, input int cnt_w);
    return cnt_w + $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vg2_popcount.sv
`default_nettype none
// ============================================================================
// Module   : vg2_popcount
// Purpose  : Combinational population count of a WIDTH-bit vector.
// Ports    : bits_i  [WIDTH-1:0] - vector to count
//            count_o [OUT_W-1:0] - number of set bits in bits_i
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module vg2_popcount #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [OUT_W-1:0] count_o
);

  logic [OUT_W-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_acc = w_acc + OUT_W'(bits_i[i]);
    end
  end

  assign count_o = w_acc;

endmodule
`default_nettype wire

// File: rtl/vg2_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vg2_activity_monitor
// Purpose  : Registers the vg2 result vector and measures its switching
//            activity over a programmable window of valid samples. Per-bit
//            and total toggle counts are reported through a valid/ready
//            handshake and serve as a power proxy.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            in_valid, in_data   - new vg2 result this cycle
//            start, win_len      - begin a window of win_len samples (IDLE)
//            busy                - window in progress
//            q_data              - registered copy of last valid in_data
//            out_valid/out_ready - result handshake
//            out_bit_cnt         - per-bit toggle counts, bit i at
//                                  [i*CNT_W +: CNT_W]
//            out_total           - saturating sum of all toggles
// Config   : VG2_ACT_PERBIT_EN - when defined, per-bit counters are built
//            and drive out_bit_cnt; otherwise out_bit_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module vg2_activity_monitor
  import vg2_act_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                start,
  input  logic [WIN_W-1:0]                    win_len,
  output logic                                busy,
  output logic [WIDTH-1:0]                    q_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH*CNT_W-1:0]              out_bit_cnt,
  output logic [tot_width(WIDTH, CNT_W)-1:0]  out_total
);

  localparam int TOT_W = tot_width(WIDTH, CNT_W);
  localparam int POP_W = $clog2(WIDTH + 1);
  // One spare bit so a carry out of the total flags saturation.
  localparam int SUM_W = TOT_W + 1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_data_q;
  logic [WIN_W-1:0]   remaining_q;
  logic [TOT_W-1:0]   total_q;

  logic               w_accept;   // accepted start: load window, clear counts
  logic               w_score;    // sample counted in the current window
  logic               w_last;     // this sample completes the window
  logic [WIDTH-1:0]   w_toggle;
  logic [POP_W-1:0]   w_pop;
  logic [SUM_W-1:0]   w_sum;
  logic [TOT_W-1:0]   w_total_next;

  // --------------------------------------------------------------------------
  // Capture register: runs in every state, independent of the FSM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data_q <= '0;
    end else if (in_valid) begin
      q_data_q <= in_data;
    end
  end

  assign q_data   = q_data_q;
  // Compared against the pre-update register, so the first sample of a
  // window sees whatever was captured before it (0 after reset).
  assign w_toggle = in_data ^ q_data_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign w_last = (remaining_q == WIN_W'(1));

  always_comb begin
    state_d  = state_q;
    w_accept = 1'b0;
    w_score  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (win_len != '0)) begin
          w_accept = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          w_score = 1'b1;
          if (w_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A start arriving with out_ready is dropped; IDLE must see it again.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == HOLD);

  // --------------------------------------------------------------------------
  // Window length counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
    end else if (w_accept) begin
      remaining_q <= win_len;
    end else if (w_score) begin
      remaining_q <= remaining_q - WIN_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Total toggle counter (saturating)
  // --------------------------------------------------------------------------
  vg2_popcount #(
    .WIDTH (WIDTH),
    .OUT_W (POP_W)
  ) u_popcount (
    .bits_i  (w_toggle),
    .count_o (w_pop)
  );

  always_comb begin
    w_sum        = SUM_W'(total_q) + SUM_W'(w_pop);
    w_total_next = w_sum[TOT_W-1:0];
    if (w_sum[SUM_W-1]) begin
      w_total_next = TOT_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
    end else if (w_accept) begin
      total_q <= '0;
    end else if (w_score) begin
      total_q <= w_total_next;
    end
  end

  assign out_total = total_q;

  // --------------------------------------------------------------------------
  // Per-bit toggle counters (optional)
  // --------------------------------------------------------------------------
`ifdef VG2_ACT_PERBIT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (w_accept) begin
        cnt_q <= '0;
      end else if (w_score && w_toggle[gi] && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign out_bit_cnt[gi*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign out_bit_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vg2_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vg2_activity_monitor
// Purpose  : Directed self-checking bench for vg2_activity_monitor. Two
//            instances share all inputs: one with default parameters and
//            one with CNT_W=4 (7-bit total) to exercise saturation.
// Config   : VG2_ACT_PERBIT_EN - selects per-bit expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vg2_activity_monitor;

`ifdef VG2_ACT_PERBIT_EN
  localparam bit PERBIT = 1'b1;
`else
  localparam bit PERBIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        start = 1'b0;
  logic [15:0] win_len = 16'd0;
  logic        out_ready = 1'b0;

  // Default instance (CNT_W=16, total width 19)
  logic          busy_b, out_valid_b;
  logic [7:0]    q_data_b;
  logic [127:0]  bit_cnt_b;
  logic [18:0]   total_b;

  // Small instance (CNT_W=4, total width 7)
  logic          busy_s, out_valid_s;
  logic [7:0]    q_data_s;
  logic [31:0]   bit_cnt_s;
  logic [6:0]    total_s;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vg2_activity_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .start       (start),
    .win_len     (win_len),
    .busy        (busy_b),
    .q_data      (q_data_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready),
    .out_bit_cnt (bit_cnt_b),
    .out_total   (total_b)
  );

  vg2_activity_monitor #(.CNT_W(4)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .start       (start),
    .win_len     (win_len),
    .busy        (busy_s),
    .q_data      (q_data_s),
    .out_valid   (out_valid_s),
    .out_ready   (out_ready),
    .out_bit_cnt (bit_cnt_s),
    .out_total   (total_s)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-bit expectation: the counters only exist in the per-bit build.
  function automatic logic [127:0] pb(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    if (PERBIT) r = v;
    return r;
  endfunction

  // Advance one clock; inputs and samples are taken 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [7:0] s1 [4];
    logic [7:0] d;
    bit         seen;

    s1[0] = 8'h00; s1[1] = 8'hFF; s1[2] = 8'hFF; s1[3] = 8'h0F;

    // ---------------- reset ----------------
    step(); step();
    rst = 1'b0;
    chk("rst_busy",      {127'd0, busy_b},      128'd0);
    chk("rst_out_valid", {127'd0, out_valid_b}, 128'd0);
    chk("rst_q_data",    {120'd0, q_data_b},    128'd0);
    chk("rst_total",     {109'd0, total_b},     128'd0);
    chk("rst_bit_cnt",   bit_cnt_b,             128'd0);

    // ---------------- scenario 1: win_len=4 ----------------
    start = 1'b1; win_len = 16'd4;
    step();
    start = 1'b0;
    chk("s1_busy_rise", {127'd0, busy_b}, 128'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = s1[i];
      step();
      chk("s1_q_data",    {120'd0, q_data_b},    {120'd0, s1[i]});
      chk("s1_out_valid", {127'd0, out_valid_b}, {127'd0, (i == 3)});
    end
    in_valid = 1'b0;
    // Toggle vectors 00, FF, 00, F0: bits 0..3 toggle once, bits 4..7 twice.
    chk("s1_total_b", {109'd0, total_b}, 128'd12);
    chk("s1_total_s", {121'd0, total_s}, 128'd12);
    chk("s1_bits_b",  bit_cnt_b, pb({{4{16'd2}}, {4{16'd1}}}));
    chk("s1_bits_s",  {96'd0, bit_cnt_s}, pb({96'd0, {4{4'd2}}, {4{4'd1}}}));

    // ---------------- scenario 2: HOLD freeze, then handshake ----------------
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = (i == 9) ? 8'h00 : 8'(i * 37 + 5);
      in_data = d;
      step();
      chk("s2_q_tracks", {120'd0, q_data_b}, {120'd0, d});
      chk("s2_frozen",   {109'd0, total_b},  128'd12);
    end
    in_valid = 1'b0;
    chk("s2_still_valid", {127'd0, out_valid_b}, 128'd1);
    chk("s2_bits_frozen", bit_cnt_b, pb({{4{16'd2}}, {4{16'd1}}}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("s2_valid_fall",   {127'd0, out_valid_b}, 128'd0);
    chk("s2_total_persist", {109'd0, total_b},    128'd12);

    // ---------------- scenario 3: zero length, start in RUN ----------------
    start = 1'b1; win_len = 16'd0;
    step();
    start = 1'b0;
    chk("s3_zero_len_busy", {127'd0, busy_b}, 128'd0);
    step();
    chk("s3_zero_len_idle", {127'd0, busy_b}, 128'd0);
    start = 1'b1; win_len = 16'd3;
    step();
    start = 1'b0;
    chk("s3_busy", {127'd0, busy_b}, 128'd1);
    in_valid = 1'b1;
    // Start request during RUN must not reload the window length.
    start = 1'b1; win_len = 16'd9; in_data = 8'h01;
    step();
    start = 1'b0;
    chk("s3_run_v0", {127'd0, out_valid_b}, 128'd0);
    in_data = 8'h03;
    step();
    chk("s3_run_v1", {127'd0, out_valid_b}, 128'd0);
    step();
    in_valid = 1'b0;
    chk("s3_len_kept", {127'd0, out_valid_b}, 128'd1);
    chk("s3_total_b",  {109'd0, total_b},     128'd2);
    chk("s3_bits_b",   bit_cnt_b, pb({{6{16'd0}}, 16'd1, 16'd1}));
    // start together with out_ready in HOLD is dropped.
    start = 1'b1; win_len = 16'd2; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk("s3_hs_valid", {127'd0, out_valid_b}, 128'd0);
    chk("s3_hs_busy",  {127'd0, busy_b},      128'd0);
    step();
    chk("s3_start_dropped", {127'd0, busy_b}, 128'd0);

    // ---------------- scenario 4: saturation, win_len=20 ----------------
    in_valid = 1'b1; in_data = 8'h00;
    step();
    in_valid = 1'b0;
    chk("s4_q_zero", {120'd0, q_data_b}, 128'd0);
    start = 1'b1; win_len = 16'd20;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = (i % 2 == 0) ? 8'hFF : 8'h00;
      step();
      if (i == 14) begin
        chk("s4_total_s_120", {121'd0, total_s}, 128'd120);
        chk("s4_total_b_120", {109'd0, total_b}, 128'd120);
      end
      if (i == 15) begin
        chk("s4_total_s_clamp", {121'd0, total_s}, 128'd127);
        chk("s4_total_b_128",   {109'd0, total_b}, 128'd128);
      end
    end
    in_valid = 1'b0;
    chk("s4_valid_s",   {127'd0, out_valid_s}, 128'd1);
    chk("s4_total_s",   {121'd0, total_s},     128'd127);
    chk("s4_total_b",   {109'd0, total_b},     128'd160);
    chk("s4_bits_s",    {96'd0, bit_cnt_s},    pb({96'd0, {8{4'hF}}}));
    chk("s4_bits_b",    bit_cnt_b,             pb({8{16'd20}}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // ---------------- scenario 5: async reset mid-RUN ----------------
    start = 1'b1; win_len = 16'd5;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hAA;
    step();
    in_data = 8'h55;
    step();
    chk("s5_busy_pre",  {127'd0, busy_b},  128'd1);
    chk("s5_total_pre", {109'd0, total_b}, 128'd12);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_rst_busy",   {127'd0, busy_b},      128'd0);
    chk("s5_rst_valid",  {127'd0, out_valid_b}, 128'd0);
    chk("s5_rst_q",      {120'd0, q_data_b},    128'd0);
    chk("s5_rst_total",  {109'd0, total_b},     128'd0);
    chk("s5_rst_total_s", {121'd0, total_s},    128'd0);
    chk("s5_rst_bits",   bit_cnt_b,             128'd0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i * 29);
      step();
      if (out_valid_b || out_valid_s || busy_b) seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("s5_no_result", {127'd0, seen}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
